// File: rtl/axis_fixed_latency_adapter.sv
`default_nettype none
// ============================================================================
// Module   : axis_fixed_latency_adapter
// Purpose  : Couples a backpressured AXI-Stream to a fixed-latency, stall-free
//            datapath and buffers the returning results in a credit-guarded FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module axis_fixed_latency_adapter #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [IN_WIDTH-1:0]   s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,

    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    output logic [IN_WIDTH-1:0]   dp_out_tdata,
    output logic                  dp_out_stb,
    input  logic [OUT_WIDTH-1:0]  dp_in_tdata,
    input  logic                  dp_in_stb,

    output logic [DEPTH_LOG2:0]   occupancy,
    output logic                  latency_err
);

    localparam int                  c_depth     = 1 << DEPTH_LOG2;
    localparam int                  c_mask_w    = $clog2(LATENCY + 1);
    localparam logic [DEPTH_LOG2:0] c_depth_cnt = c_depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_cnt_one   = 1;
    localparam logic [c_mask_w-1:0] c_mask_init = c_mask_w'(LATENCY);
    localparam logic [c_mask_w-1:0] c_mask_one  = 1;

    logic [DEPTH_LOG2:0]   r_occ;
    logic [LATENCY-1:0]    r_dl_vld;
    logic [LATENCY-1:0]    r_dl_last;
    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic [OUT_WIDTH-1:0]  r_mem_data [c_depth];
    logic                  r_mem_last [c_depth];
    logic [c_mask_w-1:0]   r_mask_cnt;
    logic                  r_err;

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_exp_vld;
    logic                  w_exp_last;
    logic                  w_empty;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;

    // Ready depends only on the credit register, never on m_axis_tready.
    assign s_axis_tready = (r_occ < c_depth_cnt);
    assign w_in_hs       = s_axis_tvalid & s_axis_tready;
    assign w_out_hs      = m_axis_tvalid & m_axis_tready;

    assign dp_out_stb    = w_in_hs;
    assign dp_out_tdata  = s_axis_tdata;

    assign w_exp_vld     = r_dl_vld[LATENCY-1];
    assign w_exp_last    = r_dl_last[LATENCY-1];

    assign w_wr_idx      = r_wr_ptr[DEPTH_LOG2-1:0];
    assign w_rd_idx      = r_rd_ptr[DEPTH_LOG2-1:0];
    assign w_empty       = (r_wr_ptr == r_rd_ptr);

    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = r_mem_data[w_rd_idx];
    assign m_axis_tlast  = ~w_empty & r_mem_last[w_rd_idx];

    assign occupancy     = r_occ;
    assign latency_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_occ <= r_occ + c_cnt_one;
        end else if (!w_in_hs && w_out_hs) begin
            r_occ <= r_occ - c_cnt_one;
        end
    end

    generate
        if (LATENCY == 1) begin : g_dl_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dl_vld <= '0;
                end else begin
                    r_dl_vld <= w_in_hs;
                end
            end

            always_ff @(posedge clk) begin
                r_dl_last <= s_axis_tlast;
            end
        end else begin : g_dl_shift
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dl_vld <= '0;
                end else begin
                    r_dl_vld <= {r_dl_vld[LATENCY-2:0], w_in_hs};
                end
            end

            always_ff @(posedge clk) begin
                r_dl_last <= {r_dl_last[LATENCY-2:0], s_axis_tlast};
            end
        end
    endgenerate

    // Writes follow the tracked timing, not dp_in_stb, so credits stay exact
    // even when the datapath drops or invents strobes.
    always_ff @(posedge clk) begin
        if (w_exp_vld) begin
            r_mem_data[w_wr_idx] <= dp_in_tdata;
            r_mem_last[w_wr_idx] <= w_exp_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_exp_vld) begin
                r_wr_ptr <= r_wr_ptr + c_cnt_one;
            end
            if (w_out_hs) begin
                r_rd_ptr <= r_rd_ptr + c_cnt_one;
            end
        end
    end

    // Results still draining from before a reset must not raise the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask_cnt <= c_mask_init;
            r_err      <= 1'b0;
        end else if (r_mask_cnt != '0) begin
            r_mask_cnt <= r_mask_cnt - c_mask_one;
        end else if (dp_in_stb != w_exp_vld) begin
            r_err      <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_fixed_latency_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_fixed_latency_adapter
// Purpose  : Scoreboard bench for axis_fixed_latency_adapter with a 4-cycle
//            "+1" datapath model that can drop or inject result strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_fixed_latency_adapter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] dp_out_tdata;
    logic        dp_out_stb;
    logic [31:0] dp_in_tdata;
    logic        dp_in_stb;
    logic [3:0]  occupancy;
    logic        latency_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    int first_in_cyc = 0;
    int first_out_cyc = 0;
    int last_out_cyc = 0;

    axis_fixed_latency_adapter #(
        .IN_WIDTH   (32),
        .OUT_WIDTH  (32),
        .LATENCY    (4),
        .DEPTH_LOG2 (3)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .dp_out_tdata  (dp_out_tdata),
        .dp_out_stb    (dp_out_stb),
        .dp_in_tdata   (dp_in_tdata),
        .dp_in_stb     (dp_in_stb),
        .occupancy     (occupancy),
        .latency_err   (latency_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: 4-cycle delay, result = input + 1, optional fault hooks.
    logic [3:0]  mp_stb = '0;
    logic [31:0] mp_dat [4];
    int          stb_count = 0;
    int          drop_at = -1;
    logic        extra_stb = 1'b0;

    always @(posedge clk) begin
        mp_stb    <= {mp_stb[2:0], dp_out_stb && (stb_count != drop_at)};
        mp_dat[0] <= dp_out_tdata + 32'd1;
        for (int i = 1; i < 4; i++) mp_dat[i] <= mp_dat[i-1];
        if (dp_out_stb) stb_count <= stb_count + 1;
    end

    assign dp_in_stb   = mp_stb[3] | extra_stb;
    assign dp_in_tdata = mp_dat[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: expected results queued at input handshake.
    logic [32:0] sb [$];
    logic [32:0] sb_exp;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("out_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    sb_exp = sb.pop_front();
                    check("out_data", m_axis_tdata, sb_exp[31:0]);
                    check("out_last", m_axis_tlast, sb_exp[32]);
                end
                if (out_cnt == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_cnt++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                sb.push_back({s_axis_tlast, s_axis_tdata + 32'd1});
                if (in_cnt == 0) first_in_cyc = cyc;
                in_cnt++;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    task automatic clear_counts();
        in_cnt  = 0;
        out_cnt = 0;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 300 && out_cnt < n; i++) @(posedge clk);
        check("drain_count", out_cnt, n);
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input bit chk_ready);
        for (int j = 0; j < n; j++) begin
            int guard = 0;
            @(posedge clk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + j;
            s_axis_tlast  = j[0];
            @(negedge clk);
            if (chk_ready) check("tready_steady", s_axis_tready, 1);
            while (!s_axis_tready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("send_timeout", guard, 0);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic single_beat();
        clear_counts();
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0000_00A5;
        s_axis_tlast  = 1'b1;
        @(negedge clk);
        check("sb_dp_out_stb", dp_out_stb, 1);
        check("sb_dp_out_tdata", dp_out_tdata, 32'h0000_00A5);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("sb_dp_in_early", dp_in_stb, 0);
            check("sb_mvalid_early", m_axis_tvalid, 0);
        end
        @(negedge clk);
        check("sb_dp_in_stb", dp_in_stb, 1);
        check("sb_mvalid_k4", m_axis_tvalid, 0);
        @(negedge clk);
        check("sb_mvalid_k5", m_axis_tvalid, 1);
        check("sb_mdata", m_axis_tdata, 32'h0000_00A6);
        check("sb_mlast", m_axis_tlast, 1);
        check("sb_occ_busy", occupancy, 1);
        @(negedge clk);
        check("sb_occ_idle", occupancy, 0);
        check("sb_mvalid_idle", m_axis_tvalid, 0);
        check("sb_out_count", out_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;

        // Reset / idle
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_tready", s_axis_tready, 1);
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_mlast", m_axis_tlast, 0);
        check("rst_occ", occupancy, 0);
        check("rst_err", latency_err, 0);
        check("rst_stb", dp_out_stb, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);

        // Single beat
        single_beat();

        // Steady state
        clear_counts();
        send_beats(50, 32'd0, 1'b1);
        wait_out(50);
        check("ss_first_latency", first_out_cyc - first_in_cyc, 5);
        check("ss_consecutive", last_out_cyc - first_out_cyc, 49);

        // Backpressure
        repeat (4) @(posedge clk);
        clear_counts();
        #1 m_axis_tready = 1'b0;
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h100 + idx;
            s_axis_tlast  = idx[0];
            @(negedge clk);
            if (s_axis_tready) idx++;
        end
        check("bp_accepted", idx, 8);
        check("bp_occ_full", occupancy, 8);
        check("bp_tready_low", s_axis_tready, 0);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("bp_tready_first_pop", s_axis_tready, 0);
        for (int c = 0; c < 50 && idx < 12; c++) begin
            @(posedge clk); #1;
            s_axis_tdata = 32'h100 + idx;
            s_axis_tlast = idx[0];
            @(negedge clk);
            if (c == 0) check("bp_tready_reassert", s_axis_tready, 1);
            if (s_axis_tready) idx++;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_out(12);
        check("bp_in_count", in_cnt, 12);

        // Latency fault: suppressed strobe, then a stray strobe
        repeat (4) @(posedge clk);
        clear_counts();
        check("lf_err_before", latency_err, 0);
        drop_at = stb_count + 3;
        send_beats(6, 32'h200, 1'b0);
        wait_out(6);
        check("lf_err_set", latency_err, 1);
        check("lf_io_count", out_cnt, in_cnt);
        drop_at = -1;
        repeat (5) @(posedge clk);
        #1 extra_stb = 1'b1;
        @(posedge clk); #1;
        extra_stb = 1'b0;
        repeat (8) @(negedge clk);
        check("lf_stray_no_out", out_cnt, 6);
        check("lf_stray_occ", occupancy, 0);
        check("lf_stray_mvalid", m_axis_tvalid, 0);
        check("lf_err_sticky", latency_err, 1);

        // Reset mid-stream
        clear_counts();
        m_axis_tready = 1'b0;
        send_beats(5, 32'h300, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_counts();
        m_axis_tready = 1'b1;
        repeat (15) @(negedge clk);
        check("rs_no_out", out_cnt, 0);
        check("rs_err", latency_err, 0);
        check("rs_occ", occupancy, 0);
        check("rs_mvalid", m_axis_tvalid, 0);
        single_beat();
        check("rs_err_final", latency_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
